// File: rtl/rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rx_frame_ctrl
//
// Purpose:
//   Gates the receive datapath so that only checksum-validated frames reach
//   downstream game logic. Aggregated 32-bit words of the frame in flight are
//   written speculatively into a circular buffer. When the checksum checker
//   reports its result, the frame is either committed (made visible on the
//   output stream) or rolled back (speculative write pointer rewound).
//   Good/bad frame counters are provided for LED / seven-segment debug.
//
// Ports:
//   clk          Ethernet reference clock, all logic on the rising edge
//   rst          asynchronous, active-low reset
//   frame_active high while the PHY frame is in progress
//   axiiv/axiid  aggregated word strobe and data
//   done/kill    checksum result strobe; kill is meaningful only with done
//   axior        downstream ready
//   axiov/axiod  committed word available / show-ahead head-of-buffer word
//   good_cnt     frames committed (wraps)
//   bad_cnt      frames dropped: kill, overflow, timeout or preemption (wraps)
//   level        committed words currently held
// ---------------------------------------------------------------------------
module rx_frame_ctrl #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_active,
    input  logic                   axiiv,
    input  logic [31:0]            axiid,
    input  logic                   done,
    input  logic                   kill,
    input  logic                   axior,
    output logic                   axiov,
    output logic [31:0]            axiod,
    output logic [CNT_W-1:0]       good_cnt,
    output logic [CNT_W-1:0]       bad_cnt,
    output logic [$clog2(DEPTH):0] level
);

    // Pointers carry one extra bit so that full and empty are distinguishable
    // while the low bits index the buffer directly.
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] DEPTH_P    = PW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WAIT_CK,
        COMMIT,
        DROP
    } state_t;

    state_t state;
    state_t next_state;

    logic          frame_active_q;
    logic          fa_rise;
    logic          fa_fall;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] spec_wr;
    logic [PW-1:0] commit_wr;
    logic          full;
    logic          pop;
    logic          axiov_nxt;

    logic          res_v;
    logic          res_bad;
    logic          ovf;
    logic          fa_pend;
    logic [TW-1:0] timer;

    logic          wait_decide;
    logic          wait_bad;
    logic          timed_out;

    logic          wr_en;
    logic          ovf_set;
    logic          res_latch;
    logic          commit_en;
    logic          drop_en;
    logic          flags_clr;

    assign fa_rise = frame_active & ~frame_active_q;
    assign fa_fall = ~frame_active & frame_active_q;

    assign full  = (spec_wr - rd_ptr) == DEPTH_P;
    assign level = commit_wr - rd_ptr;

    // A checksum result seen during RECV takes precedence over any later
    // strobe; an overflowed frame is bad regardless of what the checker says.
    assign wait_decide = res_v | done;
    assign wait_bad    = res_v ? (res_bad | ovf) : (kill | ovf);
    assign timed_out   = (timer == TIMER_LAST);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. A new frame arriving while the previous one
    // is still waiting for its checksum preempts it and goes straight to
    // RECV; a rise seen during the one-cycle COMMIT/DROP (or latched in
    // the deciding WAIT_CK cycle) also skips IDLE so no words are lost.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (fa_rise) begin
                    next_state = RECV;
                end
            end
            RECV: begin
                if (fa_fall) begin
                    next_state = WAIT_CK;
                end
            end
            WAIT_CK: begin
                if (wait_decide) begin
                    next_state = wait_bad ? DROP : COMMIT;
                end else if (fa_rise) begin
                    next_state = RECV;
                end else if (timed_out) begin
                    next_state = DROP;
                end
            end
            COMMIT, DROP: begin
                next_state = (fa_rise | fa_pend) ? RECV : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM output strobes for the datapath
    // ------------------------------------------------------------------
    always_comb begin
        wr_en     = 1'b0;
        ovf_set   = 1'b0;
        res_latch = 1'b0;
        commit_en = 1'b0;
        drop_en   = 1'b0;
        case (state)
            RECV: begin
                wr_en     = axiiv & ~full & ~ovf;
                ovf_set   = axiiv & full;
                res_latch = done & ~res_v;
            end
            WAIT_CK: begin
                drop_en = ~wait_decide & fa_rise;
            end
            COMMIT: begin
                commit_en = 1'b1;
            end
            DROP: begin
                drop_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign flags_clr = (next_state == RECV) && (state != RECV);

    // ------------------------------------------------------------------
    // Per-frame bookkeeping: edge detect, early result latch, overflow
    // flag, pending frame start and the WAIT_CK timer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_active_q <= 1'b0;
            fa_pend        <= 1'b0;
            timer          <= '0;
            res_v          <= 1'b0;
            res_bad        <= 1'b0;
            ovf            <= 1'b0;
        end else begin
            frame_active_q <= frame_active;
            fa_pend        <= (state == WAIT_CK) && fa_rise && wait_decide;
            timer          <= (state == WAIT_CK) ? timer + TW'(1) : '0;
            if (flags_clr) begin
                res_v   <= 1'b0;
                res_bad <= 1'b0;
                ovf     <= 1'b0;
            end else begin
                if (res_latch) begin
                    res_v   <= 1'b1;
                    res_bad <= kill;
                end
                if (ovf_set) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Word buffer storage (no reset needed; validity is tracked by the
    // pointers).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[spec_wr[AW-1:0]] <= axiid;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, counters and the registered output stage.
    //
    // axiov looks at the current commit_wr but the post-pop read pointer:
    // freshly committed words show up one cycle after COMMIT, while a word
    // consumed this cycle is never presented twice. The show-ahead data is
    // reloaded only when the stage is empty or being consumed, so it holds
    // under backpressure. The read index can never collide with a write in
    // the same cycle because the buffer is never overfilled.
    // ------------------------------------------------------------------
    assign pop        = axiov & axior;
    assign rd_ptr_nxt = rd_ptr + PW'(pop);
    assign axiov_nxt  = (commit_wr != rd_ptr_nxt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            spec_wr   <= '0;
            commit_wr <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            axiov     <= 1'b0;
            axiod     <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;

            if (drop_en) begin
                spec_wr <= commit_wr;
            end else if (wr_en) begin
                spec_wr <= spec_wr + PW'(1);
            end

            if (commit_en) begin
                commit_wr <= spec_wr;
                good_cnt  <= good_cnt + CNT_W'(1);
            end

            if (drop_en) begin
                bad_cnt <= bad_cnt + CNT_W'(1);
            end

            axiov <= axiov_nxt;
            if ((!axiov || axior) && axiov_nxt) begin
                axiod <= mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

endmodule
